// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the single CPU-side RAM transaction port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on ties; default is fixed priority to port 0.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 64
) (
  input  logic              cpu_clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_width,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_width,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_width,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rstrobe,
  output logic              mem_wstrobe,
  input  logic              mem_complete,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rstb_q, rstb_d;
  logic              wstb_q, wstb_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              busy_q, busy_d;
  logic              sel;
  logic              hs;

  // Tie-break: last_q is only consulted when round-robin is enabled.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      sel = ~last_q;
`else
      sel = 1'b0;
`endif
    end
  end

  assign req0_ready = (state_q == IDLE) && mem_ready && !sel;
  assign req1_ready = (state_q == IDLE) && mem_ready && sel;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    last_d   = last_q;
    addr_d   = addr_q;
    width_d  = width_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = busy_q;
    rstb_d   = 1'b0;
    wstb_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d = sel;
          last_d  = sel;
          we_d    = sel ? req1_we    : req0_we;
          addr_d  = sel ? req1_addr  : req0_addr;
          width_d = sel ? req1_width : req0_width;
          wdata_d = sel ? req1_wdata : req0_wdata;
          rstb_d  = sel ? !req1_we   : !req0_we;
          wstb_d  = sel ? req1_we    : req0_we;
          busy_d  = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE, WAIT: begin
        // Completion may coincide with the strobe cycle itself.
        if (mem_complete) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          done0_d = !owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rstb_q   <= 1'b0;
      wstb_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rstb_q   <= rstb_d;
      wstb_q   <= wstb_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_width   = width_q;
  assign mem_wdata   = wdata_q;
  assign mem_rstrobe = rstb_q;
  assign mem_wstrobe = wstb_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign busy        = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CPU-side RAM transaction port (addr/width/data_in/data_out, rstrobe/wstrobe, transaction_complete, ready) between two requesters: port 0 (instruction fetch) and port 1 (data/LRU cache).
- Accepts one request at a time through a valid/ready handshake and holds address, width and write data stable for the whole RAM transaction.
- Drives single-cycle strobes and routes completion and read data back to the requester that owns the transaction.
- Sits in the cpu_clk domain, directly in front of the RAM controller wrapper.

Parameters:
- ADDR_W, 28, byte address width.
- DATA_W, 64, data width. Read data arrives left-justified for narrow widths.

Ports:
- cpu_clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle when valid is also high.
- req0_we  input  1  1=write, 0=read.
- req0_addr  input  ADDR_W  byte address.
- req0_width  input  2  RAM_WIDTH8/16/32/64 encoding from io_def.vh.
- req0_wdata  input  DATA_W  write data.
- req0_rdata  output  DATA_W  read data, valid while req0_done is high and held afterwards.
- req0_done  output  1  one-cycle completion pulse.
- req1_*  (same set as req0_*)  port 1.
- mem_addr  output  ADDR_W  to RAM addr.
- mem_width  output  2  to RAM width.
- mem_wdata  output  DATA_W  to RAM data_in.
- mem_rdata  input  DATA_W  from RAM data_out.
- mem_rstrobe  output  1  read strobe, one-cycle pulse.
- mem_wstrobe  output  1  write strobe, one-cycle pulse.
- mem_complete  input  1  RAM transaction_complete pulse.
- mem_ready  input  1  RAM ready (calibration/reset done).
- busy  output  1  a transaction is outstanding.

Behaviour:
- Clock and reset: one clock, cpu_clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; mem_addr, mem_width, mem_wdata, req0_rdata, req1_rdata = 0; strobes, done pulses, busy = 0; last_grant=1 (port 0 wins first tie).
- States:
  - IDLE: accepts requests.
  - STROBE: exactly one cycle; mem_rstrobe or mem_wstrobe high.
  - WAIT: waits for mem_complete.
  - DONE: exactly one cycle; reqN_done high for the owner.
- Grant selection (combinational, in IDLE only): sel = port 1 if only req1_valid; port 0 if only req0_valid; if both, per the Optional Feature.
  - reqN_ready = (state==IDLE) & mem_ready & (sel==N).
  - At most one ready is high in any cycle.
  - Ready is 0 in all other states.
- Handshake edge (valid & ready):
  - Latch owner, we, addr, width and wdata into mem_* registers.
  - Update last_grant.
  - Go to STROBE, busy=1.
- STROBE: assert the strobe matching the latched we for one cycle, then go to WAIT.
- Issue latency: handshake edge -> strobe in the following cycle.
- mem_* outputs hold unchanged from the handshake until leaving DONE.
- WAIT, on mem_complete:
  - Read: capture mem_rdata into the owner's reqN_rdata.
  - Write: leave reqN_rdata unchanged.
  - Go to DONE.
  - mem_complete arriving in the same cycle as the STROBE state is also legal; treat it as completion.
- DONE: owner's done=1 for one cycle; busy drops on the next edge; return to IDLE.
- Minimum back-to-back spacing: a new handshake is possible in the cycle after DONE.
- Boundary conditions:
  - mem_complete outside STROBE/WAIT: ignored, no state change.
  - mem_ready low in IDLE: no ready asserted; requests stall with no loss.
  - mem_ready dropping in STROBE/WAIT: ignored; the transaction still waits for mem_complete.
  - Valid dropped without handshake: no effect.
  - rst_n asserted mid-transaction: immediate return to reset values; the pending done is never issued.
  - Requester-side inputs are don't-care after the handshake.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: both valid in IDLE -> grant the port not equal to last_grant (strict alternation under continuous contention).
- Undefined: fixed priority, port 0 always wins ties. last_grant is still maintained but unused.

Test Plan:
- Single read: req0 {we=0, addr=28'h0000100, width=64}, mem_complete 10 cycles after the strobe with mem_rdata=64'h1122334455667788 -> one rstrobe pulse, mem_addr=28'h0000100 held throughout, req0_done pulse, req0_rdata=64'h1122334455667788, req1_done never asserted.
- Single write: req1 {we=1, addr=28'h0000201, width=8, wdata=64'hAB} -> one wstrobe, mem_wdata=64'hAB, req1_done after complete, req1_rdata unchanged.
- Contention, both valid continuously for 4 requests:
  - RR defined: grant order 0,1,0,1.
  - RR undefined: 0,0,0,0 with port 1 starved.
- mem_ready=0 with req0_valid held 20 cycles -> req0_ready stays 0 and no strobes; raise mem_ready -> handshake the same cycle.
- Stray mem_complete in IDLE, then rst_n pulsed low during WAIT -> no done pulses; all outputs return to reset values asynchronously; the next request completes normally.
